// File: rtl/fifo_srl_flex.sv
// fifo_srl_flex: shift-register FIFO with optional registered output stage and registered flags.
// Revision 1.0
`default_nettype none

module fifo_srl_flex #(
  parameter     MEM_STYLE  = "shiftreg",
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 32,
  parameter int OUTPUT_REG = 0,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_count,
  output logic                  if_almost_full_n,
  output logic                  if_almost_empty_n
);

  localparam int                CW       = ADDR_WIDTH + 1;
  localparam int                CAP      = DEPTH + OUTPUT_REG;
  localparam logic [CW-1:0]     C_CAP    = CW'(CAP);
  localparam logic [CW-1:0]     C_AF_LIM = CW'(CAP - AF_MARGIN);
  localparam logic [CW-1:0]     C_AE_LIM = CW'(AE_MARGIN);
  localparam logic [CW-1:0]     C_ONE    = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] C_ONE_A = ADDR_WIDTH'(1);

  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_srl_cnt;
  logic [CW-1:0]         w_count_nxt;
  logic [CW-1:0]         w_srl_cnt_nxt;
  logic                  r_full_n;
  logic                  r_empty_n;
  logic                  r_af_n;
  logic                  r_ae_n;
  logic                  w_valid_nxt;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_head_data;

  // Reset wins over same-cycle requests, so nothing is shifted in while reset is high.
  assign w_wr   = if_write & if_write_ce & r_full_n & ~reset;
  assign w_rd   = if_read & if_read_ce & r_empty_n & ~reset;
  assign w_head = r_srl_cnt[ADDR_WIDTH-1:0] - C_ONE_A;

  always_comb begin
    w_count_nxt   = r_count;
    w_srl_cnt_nxt = r_srl_cnt;
    if (w_wr && !w_rd) begin
      w_count_nxt = r_count + C_ONE;
    end else if (w_rd && !w_wr) begin
      w_count_nxt = r_count - C_ONE;
    end
    if (w_wr && !w_pop) begin
      w_srl_cnt_nxt = r_srl_cnt + C_ONE;
    end else if (w_pop && !w_wr) begin
      w_srl_cnt_nxt = r_srl_cnt - C_ONE;
    end
  end

  if (MEM_STYLE == "shiftreg") begin : g_srl
    (* shreg_extract = "yes" *) logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
      if (w_wr) begin
        r_mem[0] <= if_din;
        for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
      end
    end
    assign w_head_data = r_mem[w_head];
  end else begin : g_reg
    (* shreg_extract = "no" *) logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
      if (w_wr) begin
        r_mem[0] <= if_din;
        for (int i = 1; i < DEPTH; i++) r_mem[i] <= r_mem[i-1];
      end
    end
    assign w_head_data = r_mem[w_head];
  end

  if (OUTPUT_REG != 0) begin : g_oreg
    logic [DATA_WIDTH-1:0] r_dout;
    // Refill the output stage whenever it is empty or being drained this edge.
    assign w_pop       = (r_srl_cnt != '0) & (~r_empty_n | w_rd);
    assign w_valid_nxt = w_pop | (r_empty_n & ~w_rd);
    always_ff @(posedge clk) begin
      if (reset) begin
        r_dout <= '0;
      end else if (w_pop) begin
        r_dout <= w_head_data;
      end
    end
    assign if_dout = r_dout;
  end else begin : g_comb
    assign w_pop       = w_rd;
    assign w_valid_nxt = (w_count_nxt != '0);
    assign if_dout     = w_head_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_srl_cnt <= '0;
      r_full_n  <= 1'b1;
      r_empty_n <= 1'b0;
      r_af_n    <= 1'b1;
      r_ae_n    <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_srl_cnt <= w_srl_cnt_nxt;
      r_full_n  <= (w_count_nxt != C_CAP);
      r_empty_n <= w_valid_nxt;
      r_af_n    <= (w_count_nxt < C_AF_LIM);
      r_ae_n    <= (w_count_nxt > C_AE_LIM);
    end
  end

  assign if_full_n         = r_full_n;
  assign if_empty_n        = r_empty_n;
  assign if_count          = r_count;
  assign if_almost_full_n  = r_af_n;
  assign if_almost_empty_n = r_ae_n;

endmodule

`default_nettype wire

// File: tb/tb_fifo_srl_flex.sv
// tb_fifo_srl_flex: four fifo_srl_flex configurations driven in lockstep and checked against a queue model.
`default_nettype none

module tb_fifo_srl_flex;

  logic        clk = 1'b0;
  logic        rst, wr, wce, rd, rce;
  logic [31:0] din;

  logic [5:0]  c0, c1;
  logic [1:0]  c2, c3;
  logic        fn [4];
  logic        en [4];
  logic        afn[4];
  logic        aen[4];
  logic [31:0] dout[4];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Model: circular buffer per configuration, plus output-stage validity for registered configs.
  logic [31:0] mbuf [4][64];
  int          mcnt [4];
  int          mhd  [4];
  bit          mov  [4];
  logic [31:0] mlast[4];

  always #5 clk = ~clk;

  fifo_srl_flex #(.MEM_STYLE("shiftreg"), .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32),
                  .OUTPUT_REG(0), .AF_MARGIN(2), .AE_MARGIN(1)) u_d32_r0 (
    .clk(clk), .reset(rst), .if_full_n(fn[0]), .if_write_ce(wce), .if_write(wr), .if_din(din),
    .if_empty_n(en[0]), .if_read_ce(rce), .if_read(rd), .if_dout(dout[0]), .if_count(c0),
    .if_almost_full_n(afn[0]), .if_almost_empty_n(aen[0]));

  fifo_srl_flex #(.MEM_STYLE("register"), .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(32),
                  .OUTPUT_REG(1), .AF_MARGIN(2), .AE_MARGIN(1)) u_d32_r1 (
    .clk(clk), .reset(rst), .if_full_n(fn[1]), .if_write_ce(wce), .if_write(wr), .if_din(din),
    .if_empty_n(en[1]), .if_read_ce(rce), .if_read(rd), .if_dout(dout[1]), .if_count(c1),
    .if_almost_full_n(afn[1]), .if_almost_empty_n(aen[1]));

  fifo_srl_flex #(.MEM_STYLE("shiftreg"), .DATA_WIDTH(32), .ADDR_WIDTH(1), .DEPTH(2),
                  .OUTPUT_REG(0), .AF_MARGIN(1), .AE_MARGIN(0)) u_d2_r0 (
    .clk(clk), .reset(rst), .if_full_n(fn[2]), .if_write_ce(wce), .if_write(wr), .if_din(din),
    .if_empty_n(en[2]), .if_read_ce(rce), .if_read(rd), .if_dout(dout[2]), .if_count(c2),
    .if_almost_full_n(afn[2]), .if_almost_empty_n(aen[2]));

  fifo_srl_flex #(.MEM_STYLE("shiftreg"), .DATA_WIDTH(32), .ADDR_WIDTH(1), .DEPTH(2),
                  .OUTPUT_REG(1), .AF_MARGIN(1), .AE_MARGIN(0)) u_d2_r1 (
    .clk(clk), .reset(rst), .if_full_n(fn[3]), .if_write_ce(wce), .if_write(wr), .if_din(din),
    .if_empty_n(en[3]), .if_read_ce(rce), .if_read(rd), .if_dout(dout[3]), .if_count(c3),
    .if_almost_full_n(afn[3]), .if_almost_empty_n(aen[3]));

  function automatic int cap_of(int k);
    return (k == 0) ? 32 : (k == 1) ? 33 : (k == 2) ? 2 : 3;
  endfunction
  function automatic int or_of(int k);
    return k % 2;
  endfunction
  function automatic int af_of(int k);
    return (k < 2) ? 2 : 1;
  endfunction
  function automatic int ae_of(int k);
    return (k < 2) ? 1 : 0;
  endfunction
  function automatic logic [31:0] cnt_of(int k);
    case (k)
      0:       return {26'd0, c0};
      1:       return {26'd0, c1};
      2:       return {30'd0, c2};
      default: return {30'd0, c3};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock: decide acceptance from model state, advance the model, then compare after the edge.
  task automatic step();
    bit wa[4];
    bit ra[4];
    int srl[4];
    for (int k = 0; k < 4; k++) begin
      bit fne, ene;
      fne    = (mcnt[k] != cap_of(k));
      ene    = (or_of(k) != 0) ? mov[k] : (mcnt[k] != 0);
      wa[k]  = !rst && wr && wce && fne;
      ra[k]  = !rst && rd && rce && ene;
      srl[k] = mcnt[k] - ((or_of(k) != 0) ? int'(mov[k]) : 0);
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        mcnt[k]  = 0;
        mhd[k]   = 0;
        mov[k]   = 1'b0;
        mlast[k] = '0;
      end else begin
        if (ra[k]) begin
          mhd[k]  = (mhd[k] + 1) % 64;
          mcnt[k] = mcnt[k] - 1;
        end
        if (wa[k]) begin
          mbuf[k][(mhd[k] + mcnt[k]) % 64] = din;
          mcnt[k] = mcnt[k] + 1;
        end
        if (or_of(k) != 0) mov[k] = (srl[k] > 0) || (mov[k] && !ra[k]);
      end
    end
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) begin
      bit ev;
      ev = (or_of(k) != 0) ? mov[k] : (mcnt[k] != 0);
      chk($sformatf("count[%0d]", k), cnt_of(k), 32'(mcnt[k]));
      chk($sformatf("full_n[%0d]", k), 32'(fn[k]), 32'(mcnt[k] != cap_of(k)));
      chk($sformatf("empty_n[%0d]", k), 32'(en[k]), 32'(ev));
      chk($sformatf("almost_full_n[%0d]", k), 32'(afn[k]), 32'(mcnt[k] < cap_of(k) - af_of(k)));
      chk($sformatf("almost_empty_n[%0d]", k), 32'(aen[k]), 32'(mcnt[k] > ae_of(k)));
      if (ev) begin
        mlast[k] = mbuf[k][mhd[k]];
        chk($sformatf("dout[%0d]", k), dout[k], mlast[k]);
      end else if (or_of(k) != 0) begin
        chk($sformatf("dout_hold[%0d]", k), dout[k], mlast[k]);
      end
    end
  endtask

  initial begin
    int pw, pr;
    for (int k = 0; k < 4; k++) begin
      mcnt[k] = 0; mhd[k] = 0; mov[k] = 1'b0; mlast[k] = '0;
    end
    rst = 1'b1; wr = 1'b0; wce = 1'b1; rd = 1'b0; rce = 1'b1; din = '0;
    step(); step();
    rst = 1'b0;
    chk("reset_count", cnt_of(0), 32'd0);
    chk("reset_empty_n", 32'(en[0]), 32'd0);
    chk("reset_full_n", 32'(fn[0]), 32'd1);
    chk("reset_dout_oreg", dout[1], 32'd0);

    // Latency from empty: one edge combinational, two edges registered.
    wr = 1'b1; din = 32'hA5;
    step();
    wr = 1'b0;
    chk("lat1_empty_n", 32'(en[0]), 32'd1);
    chk("lat1_dout", dout[0], 32'hA5);
    chk("lat2_not_yet", 32'(en[1]), 32'd0);
    step();
    chk("lat2_empty_n", 32'(en[1]), 32'd1);
    chk("lat2_dout", dout[1], 32'hA5);
    rd = 1'b1;
    repeat (3) step();
    rd = 1'b0;

    // Fill to capacity; the 33rd write must be dropped by the default config.
    rst = 1'b1; step(); rst = 1'b0;
    wr = 1'b1;
    for (int i = 0; i < 32; i++) begin
      din = 32'(i);
      step();
      if (i == 28) chk("af_n_at_29", 32'(afn[0]), 32'd1);
      if (i == 29) chk("af_n_at_30", 32'(afn[0]), 32'd0);
    end
    chk("full_count", cnt_of(0), 32'd32);
    chk("full_flag", 32'(fn[0]), 32'd0);
    din = 32'd999;
    step();
    chk("overflow_ignored", cnt_of(0), 32'd32);

    // Full with continuous read+write requests.
    rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din = 32'(100 + i);
      step();
      if (i == 0) chk("full_rw_read_only", cnt_of(0), 32'd31);
    end
    wr = 1'b0; rd = 1'b0;

    // Steady occupancy of 5 under simultaneous traffic.
    rst = 1'b1; step(); rst = 1'b0;
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin din = 32'(200 + i); step(); end
    rd = 1'b1;
    for (int i = 0; i < 20; i++) begin din = 32'(300 + i); step(); end
    chk("steady_count5", cnt_of(0), 32'd5);
    wr = 1'b0; rd = 1'b0;

    // Mid-operation reset with a concurrent write.
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin din = 32'(400 + i); step(); end
    chk("pre_reset_count", cnt_of(0), 32'd10);
    rst = 1'b1; din = 32'hDEAD; step();
    rst = 1'b0; wr = 1'b0;
    chk("midreset_count", cnt_of(0), 32'd0);
    chk("midreset_empty_n", 32'(en[0]), 32'd0);
    chk("midreset_full_n", 32'(fn[0]), 32'd1);
    step();
    chk("midreset_word_dropped", cnt_of(0), 32'd0);

    // Randomized traffic in phases of differing write/read pressure.
    pw = 50; pr = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 500 == 0) begin
        pw = $urandom_range(10, 95);
        pr = $urandom_range(10, 95);
      end
      rst = ($urandom_range(0, 999) == 0);
      wr  = ($urandom_range(0, 99) < pw);
      rd  = ($urandom_range(0, 99) < pr);
      wce = ($urandom_range(0, 9) != 0);
      rce = ($urandom_range(0, 9) != 0);
      din = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
